uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 195 +++++++++++++++++++
 tb/tb_uart_rx.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8-bit asynchronous serial receiver: 2-flop synchronizer, mid-bit sampling, ready/valid output.
// Optional even-parity bit enabled by defining UART_RX_PARITY_EN.
`timescale 1ns/1ps

module uart_rx #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BODE_RATE = 115_200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_data_valid,
    input  logic       rx_data_ready,
    output logic       rx_busy,
    output logic       rx_frame_err,
    output logic       rx_overrun,
    output logic       rx_parity_err
);

    localparam int          CYCLE     = CLK_FREQ / BODE_RATE;
    localparam int          HALF      = CYCLE / 2;
    localparam logic [15:0] CYC_LAST  = 16'(CYCLE - 1);
    localparam logic [15:0] HALF_LAST = 16'(HALF - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_e;

    state_e      state_q;
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;
    logic [2:0]  bit_cnt_q;
    logic [7:0]  shift_q;
    logic        rx_s0;
    logic        rx_s1;
    logic [1:0]  sync_vld_q;
    logic        rx_hi_q;
    logic [7:0]  data_q;
    logic        valid_q;
    logic        busy_q;
    logic        frame_err_q;
    logic        overrun_q;
    logic        cyc_done_s;
    logic        half_done_s;
    logic        fall_s;
    logic        consume_s;

`ifdef UART_RX_PARITY_EN
    logic        par_bad_q;
    logic        par_err_q;

    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction

    assign rx_parity_err = par_err_q;
`else
    assign rx_parity_err = 1'b0;
`endif

    assign cnt_d       = cnt_q + 16'd1;
    assign cyc_done_s  = (cnt_q == CYC_LAST);
    assign half_done_s = (cnt_q == HALF_LAST);
    // rx_hi_q only reflects genuine line samples, so a line held low through reset cannot fake an edge.
    assign fall_s      = rx_hi_q & ~rx_s1;
    assign consume_s   = valid_q & rx_data_ready;

    assign rx_data       = data_q;
    assign rx_data_valid = valid_q;
    assign rx_busy       = busy_q;
    assign rx_frame_err  = frame_err_q;
    assign rx_overrun    = overrun_q;

    // Synchronizer, receive FSM and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= 16'd0;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'd0;
            rx_s0       <= 1'b1;
            rx_s1       <= 1'b1;
            sync_vld_q  <= 2'b00;
            rx_hi_q     <= 1'b0;
            data_q      <= 8'd0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q   <= 1'b0;
            par_err_q   <= 1'b0;
`endif
        end else begin
            rx_s0       <= rx;
            rx_s1       <= rx_s0;
            sync_vld_q  <= {sync_vld_q[0], 1'b1};
            rx_hi_q     <= sync_vld_q[1] & rx_s1;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err_q   <= 1'b0;
`endif
            if (consume_s) begin
                valid_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    cnt_q <= 16'd0;
                    if (fall_s) begin
                        state_q <= START;
                        busy_q  <= 1'b1;
                    end
                end
                START: begin
                    if (half_done_s) begin
                        cnt_q <= 16'd0;
                        if (!rx_s1) begin
                            state_q   <= DATA;
                            bit_cnt_q <= 3'd0;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                DATA: begin
                    if (cyc_done_s) begin
                        cnt_q              <= 16'd0;
                        shift_q[bit_cnt_q] <= rx_s1;
                        if (bit_cnt_q == 3'd7) begin
                            bit_cnt_q <= 3'd0;
`ifdef UART_RX_PARITY_EN
                            state_q   <= PARITY;
`else
                            state_q   <= STOP;
`endif
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (cyc_done_s) begin
                        cnt_q     <= 16'd0;
                        par_bad_q <= (rx_s1 != even_parity(shift_q));
                        state_q   <= STOP;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
`endif
                STOP: begin
                    if (cyc_done_s) begin
                        // Leave at mid-stop so the next start edge is never missed.
                        cnt_q   <= 16'd0;
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        if (!rx_s1) begin
                            frame_err_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
                        end else if (par_bad_q) begin
                            par_err_q <= 1'b1;
`endif
                        end else if (!valid_q || rx_data_ready) begin
                            data_q  <= shift_q;
                            valid_q <= 1'b1;
                        end else begin
                            overrun_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    cnt_q   <= 16'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: drives serial frames, scoreboards received bytes and flag pulses.
`timescale 1ns/1ps

module tb_uart_rx;

    localparam int CYCLE = 868;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_data_valid;
    logic       rx_data_ready;
    logic       rx_busy;
    logic       rx_frame_err;
    logic       rx_overrun;
    logic       rx_parity_err;

    int         n_cmp;
    int         n_err;
    logic [7:0] exp_q[$];
    logic [7:0] exp_b;
    int         valid_cycles;
    int         frame_cnt;
    int         ovr_cnt;
    int         par_cnt;
    logic       prev_valid;
    int         v0;
    int         f0;
    int         o0;
    int         p0;

    uart_rx #(
        .CLK_FREQ (100_000_000),
        .BODE_RATE(115_200)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx           (rx),
        .rx_data      (rx_data),
        .rx_data_valid(rx_data_valid),
        .rx_data_ready(rx_data_ready),
        .rx_busy      (rx_busy),
        .rx_frame_err (rx_frame_err),
        .rx_overrun   (rx_overrun),
        .rx_parity_err(rx_parity_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        wait_cyc(CYCLE);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_b);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(^b);
`endif
        send_bit(stop_b);
        rx = 1'b1;
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic send_par_byte(input logic [7:0] b, input logic par_b);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(par_b);
        send_bit(1'b1);
        rx = 1'b1;
    endtask
`endif

    // Output monitor: counts pulses and checks every newly presented byte against the scoreboard.
    always @(negedge clk) begin
        if (rx_data_valid === 1'b1) valid_cycles++;
        if (rx_frame_err === 1'b1) frame_cnt++;
        if (rx_overrun === 1'b1) ovr_cnt++;
        if (rx_parity_err === 1'b1) par_cnt++;
        if (rx_data_valid === 1'b1 && prev_valid !== 1'b1) begin
            check("unexpected_valid", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                exp_b = exp_q.pop_front();
                check("rx_data", 32'(rx_data), 32'(exp_b));
            end
        end
        prev_valid = rx_data_valid;
    end

    initial begin
        n_cmp = 0; n_err = 0;
        valid_cycles = 0; frame_cnt = 0; ovr_cnt = 0; par_cnt = 0;
        prev_valid = 1'b0;
        rst = 1'b0;
        rx = 1'b1;
        rx_data_ready = 1'b1;
        wait_cyc(4);

        check("reset_busy", 32'(rx_busy), 32'd0);
        check("reset_valid", 32'(rx_data_valid), 32'd0);
        check("reset_data", 32'(rx_data), 32'd0);
        check("reset_frame_err", 32'(rx_frame_err), 32'd0);
        check("reset_overrun", 32'(rx_overrun), 32'd0);
        check("reset_parity_err", 32'(rx_parity_err), 32'd0);

        // Line already low when reset is released must not start a frame.
        rx = 1'b0;
        wait_cyc(2);
        rst = 1'b1;
        wait_cyc(50);
        check("low_release_busy_early", 32'(rx_busy), 32'd0);
        wait_cyc(1000);
        check("low_release_busy_late", 32'(rx_busy), 32'd0);
        rx = 1'b1;
        wait_cyc(20);

        // 0xA5 8N1 with ready high.
        v0 = valid_cycles; f0 = frame_cnt; o0 = ovr_cnt;
        exp_q.push_back(8'hA5);
        send_byte(8'hA5, 1'b1);
        wait_cyc(20);
        check("a5_valid_one_cycle", 32'(valid_cycles - v0), 32'd1);
        check("a5_data_held", 32'(rx_data), 32'hA5);
        check("a5_no_frame_err", 32'(frame_cnt - f0), 32'd0);
        check("a5_no_overrun", 32'(ovr_cnt - o0), 32'd0);
        check("a5_scoreboard_empty", 32'(exp_q.size()), 32'd0);

        // 300-cycle glitch is rejected at the half-bit sample.
        v0 = valid_cycles; f0 = frame_cnt; o0 = ovr_cnt;
        rx = 1'b0;
        wait_cyc(300);
        rx = 1'b1;
        wait_cyc(120);
        check("glitch_busy_high", 32'(rx_busy), 32'd1);
        wait_cyc(40);
        check("glitch_busy_low", 32'(rx_busy), 32'd0);
        check("glitch_no_valid", 32'(valid_cycles - v0), 32'd0);
        check("glitch_no_frame_err", 32'(frame_cnt - f0), 32'd0);
        check("glitch_no_overrun", 32'(ovr_cnt - o0), 32'd0);

        // 0x3C with a low stop bit.
        v0 = valid_cycles; f0 = frame_cnt;
        send_byte(8'h3C, 1'b0);
        wait_cyc(20);
        check("3c_frame_err_once", 32'(frame_cnt - f0), 32'd1);
        check("3c_no_valid", 32'(valid_cycles - v0), 32'd0);
        check("3c_valid_low", 32'(rx_data_valid), 32'd0);
        check("3c_data_unchanged", 32'(rx_data), 32'hA5);

        // Overrun: 0x11 held unconsumed, 0x22 dropped.
        o0 = ovr_cnt;
        rx_data_ready = 1'b0;
        exp_q.push_back(8'h11);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        wait_cyc(20);
        check("ovr_data", 32'(rx_data), 32'h11);
        check("ovr_valid", 32'(rx_data_valid), 32'd1);
        check("ovr_pulse_once", 32'(ovr_cnt - o0), 32'd1);
        check("ovr_scoreboard_empty", 32'(exp_q.size()), 32'd0);
        rx_data_ready = 1'b1;
        wait_cyc(1);
        check("ovr_consumed", 32'(rx_data_valid), 32'd0);

        // Reset mid-DATA of 0x55 aborts it; 0x0F follows cleanly.
        v0 = valid_cycles;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        wait_cyc(CYCLE / 2);
        check("mid_data_busy", 32'(rx_busy), 32'd1);
        rst = 1'b0;
        rx = 1'b1;
        wait_cyc(1);
        rst = 1'b1;
        check("abort_busy", 32'(rx_busy), 32'd0);
        check("abort_data_cleared", 32'(rx_data), 32'd0);
        wait_cyc(2 * CYCLE);
        check("abort_idle_busy", 32'(rx_busy), 32'd0);
        check("abort_no_valid", 32'(valid_cycles - v0), 32'd0);
        exp_q.push_back(8'h0F);
        send_byte(8'h0F, 1'b1);
        wait_cyc(20);
        check("0f_data", 32'(rx_data), 32'h0F);
        check("0f_valid_one_cycle", 32'(valid_cycles - v0), 32'd1);

`ifdef UART_RX_PARITY_EN
        // 0x07 needs parity 1; sending 0 must drop it.
        v0 = valid_cycles; p0 = par_cnt;
        send_par_byte(8'h07, 1'b0);
        wait_cyc(20);
        check("par_err_once", 32'(par_cnt - p0), 32'd1);
        check("par_no_valid", 32'(valid_cycles - v0), 32'd0);
        check("par_data_unchanged", 32'(rx_data), 32'h0F);
        exp_q.push_back(8'h07);
        send_byte(8'h07, 1'b1);
        wait_cyc(20);
        check("par_good_data", 32'(rx_data), 32'h07);
        check("par_good_no_err", 32'(par_cnt - p0), 32'd1);
`else
        check("parity_err_never", 32'(par_cnt), 32'd0);
`endif

        check("final_scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
